// File: rtl/m_ifetch_pkg.sv
// Shared definitions for the instruction fetch requester: state encoding,
// PC width and default PC increment.
package m_ifetch_pkg;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] PC_STEP_DEF = 32'd4;

  typedef enum logic [1:0] {
    IFS_IDLE = 2'd0,
    IFS_REQ  = 2'd1,
    IFS_WAIT = 2'd2,
    IFS_HOLD = 2'd3
  } ifs_e;

  // Sequential PC advance; wraps silently at 2^32.
  function automatic logic [PC_W-1:0] pcAdvance(input logic [PC_W-1:0] pc,
                                                 input logic [PC_W-1:0] step);
    return pc + step;
  endfunction

endpackage

// File: rtl/m_ifetch.sv
// Fetch-side requester for the multi-cycle instruction memory: one request in
// flight, skid-held result to decode, redirect with stale-return discard.
// Optional wait timeout with sticky error is enabled by IFETCH_TIMEOUT_EN.
module m_ifetch
  import m_ifetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0,
  parameter logic [PC_W-1:0] PC_STEP  = PC_STEP_DEF
`ifdef IFETCH_TIMEOUT_EN
  , parameter int TIMEOUT = 16
`endif
) (
  input  logic            w_clk,
  input  logic            w_rst_n,
  input  logic            w_en,
  input  logic            w_redir,
  input  logic [PC_W-1:0] w_redir_pc,
  output logic [PC_W-1:0] w_pc,
  output logic            w_re,
  input  logic [PC_W-1:0] w_insn,
  input  logic            w_oe,
  output logic [PC_W-1:0] w_ir,
  output logic [PC_W-1:0] w_ir_pc,
  output logic            w_ir_valid,
  input  logic            w_ir_ready,
  output logic            w_err
);

  ifs_e            state_q;
  logic [PC_W-1:0] rPc_q;
  logic [PC_W-1:0] pc_q;
  logic            re_q;
  logic [PC_W-1:0] ir_q;
  logic [PC_W-1:0] irPc_q;
  logic            irValid_q;
  logic            drop_q;

`ifdef IFETCH_TIMEOUT_EN
  localparam logic [4:0] WAIT_LAST = 5'(TIMEOUT - 1);
  logic [4:0] waitCnt_q;
  logic       err_q;
`endif

  // Redirect is applied first and every state branch below defers to it,
  // so a redirect in any state wins over the normal transition.
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      state_q   <= IFS_IDLE;
      rPc_q     <= RESET_PC;
      pc_q      <= RESET_PC;
      re_q      <= 1'b0;
      ir_q      <= '0;
      irPc_q    <= '0;
      irValid_q <= 1'b0;
      drop_q    <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
      waitCnt_q <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      re_q <= 1'b0;
      if (w_redir) begin
        rPc_q     <= w_redir_pc;
        irValid_q <= 1'b0;
      end
      case (state_q)
        IFS_IDLE: begin
          if (!w_redir && w_en) begin
            state_q <= IFS_REQ;
            re_q    <= 1'b1;
            pc_q    <= rPc_q;
          end
        end
        IFS_REQ: begin
          state_q <= IFS_WAIT;
          if (w_redir) drop_q <= 1'b1;
`ifdef IFETCH_TIMEOUT_EN
          waitCnt_q <= '0;
`endif
        end
        IFS_WAIT: begin
          if (w_oe) begin
            if (w_redir || drop_q) begin
              drop_q  <= 1'b0;
              state_q <= IFS_IDLE;
            end else begin
              ir_q      <= w_insn;
              irPc_q    <= rPc_q;
              irValid_q <= 1'b1;
              state_q   <= IFS_HOLD;
            end
          end else begin
            if (w_redir) drop_q <= 1'b1;
`ifdef IFETCH_TIMEOUT_EN
            // Giving up abandons the request entirely, so any pending drop is moot.
            if (waitCnt_q == WAIT_LAST) begin
              err_q   <= 1'b1;
              drop_q  <= 1'b0;
              state_q <= IFS_IDLE;
            end else begin
              waitCnt_q <= waitCnt_q + 5'd1;
            end
`endif
          end
        end
        IFS_HOLD: begin
          if (w_redir) begin
            state_q <= IFS_IDLE;
          end else if (w_ir_ready) begin
            rPc_q     <= pcAdvance(rPc_q, PC_STEP);
            irValid_q <= 1'b0;
            state_q   <= IFS_IDLE;
          end
        end
        default: state_q <= IFS_IDLE;
      endcase
    end
  end

  assign w_pc       = pc_q;
  assign w_re       = re_q;
  assign w_ir       = ir_q;
  assign w_ir_pc    = irPc_q;
  assign w_ir_valid = irValid_q;

`ifdef IFETCH_TIMEOUT_EN
  assign w_err = err_q;
`else
  assign w_err = 1'b0;
`endif

endmodule

// File: tb/tb_m_ifetch.sv
// Directed scoreboard bench for m_ifetch with a latency-3 imem model
// (data = 32'h1000 + address). Timeout scenario runs when IFETCH_TIMEOUT_EN is set.
module tb_m_ifetch;

  logic        w_clk;
  logic        w_rst_n;
  logic        w_en;
  logic        w_redir;
  logic [31:0] w_redir_pc;
  logic [31:0] w_pc;
  logic        w_re;
  logic [31:0] w_insn;
  logic        w_oe;
  logic [31:0] w_ir;
  logic [31:0] w_ir_pc;
  logic        w_ir_valid;
  logic        w_ir_ready;
  logic        w_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] reqQ[$];
  logic [31:0] irQ[$];
  logic [31:0] irPcQ[$];

  logic        imOe     = 1'b0;
  logic [31:0] imInsn   = '0;
  logic        strayOe  = 1'b0;
  logic        mute     = 1'b0;
  logic        pend     = 1'b0;
  logic [1:0]  cnt      = '0;
  logic [31:0] pendAddr = '0;
  logic        prevRe   = 1'b0;
  logic [31:0] monExp;
  logic [31:0] monExpPc;

  assign w_oe   = imOe | strayOe;
  assign w_insn = imInsn;

  m_ifetch dut (
    .w_clk      (w_clk),
    .w_rst_n    (w_rst_n),
    .w_en       (w_en),
    .w_redir    (w_redir),
    .w_redir_pc (w_redir_pc),
    .w_pc       (w_pc),
    .w_re       (w_re),
    .w_insn     (w_insn),
    .w_oe       (w_oe),
    .w_ir       (w_ir),
    .w_ir_pc    (w_ir_pc),
    .w_ir_valid (w_ir_valid),
    .w_ir_ready (w_ir_ready),
    .w_err      (w_err)
  );

  initial begin
    w_clk = 1'b0;
    forever #5 w_clk = ~w_clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic ready);
    w_en       = en;
    w_ir_ready = ready;
  endtask

  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  task automatic doReset();
    w_rst_n = 1'b0;
    w_redir = 1'b0;
    w_redir_pc = '0;
    applyStimulus(1'b0, 1'b0);
    tick();
    tick();
    checkOutput("rst_re", w_re, 0);
    checkOutput("rst_pc", w_pc, 32'h0);
    checkOutput("rst_valid", w_ir_valid, 0);
    checkOutput("rst_ir", w_ir, 32'h0);
    checkOutput("rst_irpc", w_ir_pc, 32'h0);
    checkOutput("rst_err", w_err, 0);
    w_rst_n = 1'b1;
  endtask

  task automatic pushReq(input logic [31:0] pc);
    reqQ.push_back(pc);
  endtask

  task automatic pushIr(input logic [31:0] pc);
    irQ.push_back(32'h1000 + pc);
    irPcQ.push_back(pc);
  endtask

  task automatic waitQueuesEmpty(input int maxCycles);
    for (int i = 0; i < maxCycles; i++) begin
      if (reqQ.size() == 0 && irQ.size() == 0) break;
      tick();
    end
    checkOutput("drain_req", reqQ.size(), 0);
    checkOutput("drain_ir", irQ.size(), 0);
  endtask

  task automatic waitReqEmpty(input int maxCycles);
    for (int i = 0; i < maxCycles; i++) begin
      if (reqQ.size() == 0) break;
      tick();
    end
    checkOutput("wait_req", reqQ.size(), 0);
  endtask

  task automatic waitValid(input int maxCycles);
    for (int i = 0; i < maxCycles; i++) begin
      tick();
      if (w_ir_valid) break;
    end
    checkOutput("wait_valid", w_ir_valid, 1);
  endtask

  // Latency-3 imem: a request seen on one falling edge returns data three
  // falling edges later, for one cycle. Shares the DUT reset.
  always @(negedge w_clk) begin
    imOe = 1'b0;
    if (!w_rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (cnt == 2'd1) begin
          pend = 1'b0;
          if (!mute) begin
            imOe   = 1'b1;
            imInsn = 32'h1000 + pendAddr;
          end
        end else begin
          cnt = cnt - 2'd1;
        end
      end
      if (w_re) begin
        pend     = 1'b1;
        cnt      = 2'd3;
        pendAddr = w_pc;
      end
    end
  end

  // Scoreboard: every request and every decode handshake must match the
  // next expected entry; anything beyond the expectation is an error.
  always @(negedge w_clk) begin
    if (w_rst_n) begin
      if (w_re) begin
        checkOutput("re_gap", {31'b0, prevRe}, 0);
        if (reqQ.size() == 0) begin
          checkOutput("unexp_re", w_re, 0);
        end else begin
          monExp = reqQ.pop_front();
          checkOutput("req_pc", w_pc, monExp);
        end
      end
      if (w_ir_valid && w_ir_ready) begin
        if (irQ.size() == 0) begin
          checkOutput("unexp_ir", w_ir_valid, 0);
        end else begin
          monExp   = irQ.pop_front();
          monExpPc = irPcQ.pop_front();
          checkOutput("ir_data", w_ir, monExp);
          checkOutput("ir_pc", w_ir_pc, monExpPc);
        end
      end
    end
    prevRe = w_re;
  end

  initial begin
    w_rst_n = 1'b0;
    w_redir = 1'b0;
    w_redir_pc = '0;
    applyStimulus(1'b0, 1'b0);

    // Streaming fetch of three instructions with decode always ready.
    doReset();
    pushReq(32'h0); pushReq(32'h4); pushReq(32'h8);
    pushIr(32'h0);  pushIr(32'h4);  pushIr(32'h8);
    applyStimulus(1'b1, 1'b1);
    waitQueuesEmpty(100);
    applyStimulus(1'b0, 1'b1);
    repeat (8) tick();

    // Decode back-pressure: held instruction must stay put, no new request.
    doReset();
    pushReq(32'h0);
    applyStimulus(1'b1, 1'b0);
    waitValid(20);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("hold_valid", w_ir_valid, 1);
      checkOutput("hold_ir", w_ir, 32'h1000);
      checkOutput("hold_irpc", w_ir_pc, 32'h0);
    end
    pushIr(32'h0); pushIr(32'h4);
    pushReq(32'h4); pushReq(32'h8);
    applyStimulus(1'b1, 1'b1);

    // Redirect one cycle after the request for pc 8: its return is dropped.
    waitReqEmpty(60);
    w_redir = 1'b1;
    w_redir_pc = 32'h40;
    tick();
    w_redir = 1'b0;
    pushReq(32'h40);
    pushIr(32'h40);
    for (int i = 0; i < 3; i++) begin
      checkOutput("drop_valid", w_ir_valid, 0);
      tick();
    end
    waitQueuesEmpty(60);
    applyStimulus(1'b0, 1'b1);
    repeat (4) tick();

    // Redirect coincident with the decode handshake of 1004.
    doReset();
    pushReq(32'h0);
    applyStimulus(1'b1, 1'b0);
    waitValid(20);
    pushIr(32'h0);
    pushReq(32'h4);
    applyStimulus(1'b1, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0);
    waitValid(20);
    checkOutput("hs_ir", w_ir, 32'h1004);
    checkOutput("hs_irpc", w_ir_pc, 32'h4);
    pushIr(32'h4);
    pushReq(32'h80);
    w_redir = 1'b1;
    w_redir_pc = 32'h80;
    applyStimulus(1'b1, 1'b1);
    tick();
    w_redir = 1'b0;
    applyStimulus(1'b1, 1'b0);
    checkOutput("hs_valid_clr", w_ir_valid, 0);
    waitValid(20);
    checkOutput("redir_ir", w_ir, 32'h1080);
    checkOutput("redir_irpc", w_ir_pc, 32'h80);
    applyStimulus(1'b0, 1'b0);
    checkOutput("redir_reqq", reqQ.size(), 0);
    checkOutput("redir_irq", irQ.size(), 0);

    // Reset while a request is outstanding, then restart from RESET_PC.
    doReset();
    pushReq(32'h0);
    applyStimulus(1'b1, 1'b1);
    waitReqEmpty(20);
    w_rst_n = 1'b0;
    tick();
    checkOutput("midrst_re", w_re, 0);
    checkOutput("midrst_valid", w_ir_valid, 0);
    checkOutput("midrst_pc", w_pc, 32'h0);
    w_rst_n = 1'b1;
    pushReq(32'h0);
    pushIr(32'h0);
    waitQueuesEmpty(40);
    applyStimulus(1'b0, 1'b1);
    repeat (6) tick();

`ifdef IFETCH_TIMEOUT_EN
    // Memory never answers: error after 16 wait cycles, stray return ignored.
    doReset();
    mute = 1'b1;
    pushReq(32'h0);
    applyStimulus(1'b1, 1'b1);
    waitReqEmpty(20);
    applyStimulus(1'b0, 1'b1);
    repeat (15) tick();
    checkOutput("to_err_early", w_err, 0);
    tick();
    checkOutput("to_err", w_err, 1);
    checkOutput("to_re", w_re, 0);
    strayOe = 1'b1;
    tick();
    strayOe = 1'b0;
    repeat (2) tick();
    checkOutput("to_stray_valid", w_ir_valid, 0);
    checkOutput("to_err_sticky", w_err, 1);
    mute = 1'b0;
    pushReq(32'h0);
    pushIr(32'h0);
    applyStimulus(1'b1, 1'b1);
    waitQueuesEmpty(40);
    applyStimulus(1'b0, 1'b1);
    repeat (6) tick();
    checkOutput("to_err_final", w_err, 1);
`else
    checkOutput("err_tied", w_err, 0);
`endif

    checkOutput("final_reqq", reqQ.size(), 0);
    checkOutput("final_irq", irQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
